tick_generator: RTL and testbench
=================================

# tick_generator

Parametrised, run-time programmable tick generator clocked by CLOCK_50. It produces single-cycle `tick` pulses every `period` clock cycles in periodic mode, or a single delayed pulse after a `start` request in one-shot mode. It also keeps a wrapping count of emitted ticks. It replaces fixed-constant delay counters in the pong datapath: ball/paddle motion timing, serve delays and score-display timeouts.

## Interface
- `WIDTH`, 26: width of the period counter and of `period_in`/`period`.
- `DEFAULT_PERIOD`, 150000: period loaded at reset. Must be ≥ 1 and < 2^WIDTH.
- `CNT_WIDTH`, 8: width of `tick_count`.
- `CLOCK_50`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high global reset.
- `enable`  in  1  1 = counter advances; 0 = counter frozen (pause), no ticks.
- `mode`  in  1  0 = periodic, 1 = one-shot.
- `start`  in  1  one-shot trigger/restart (single-cycle pulse expected; level tolerated). Ignored in periodic mode.
- `period_load`  in  1  loads `period_in` into the period register.
- `period_in`  in  WIDTH  new period in cycles; values 0 and 1 are both stored as 1.
- `tick`  out  1  registered single-cycle pulse.
- `busy`  out  1  1 while the counter is in RUN state.
- `tick_count`  out  CNT_WIDTH  ticks emitted since reset; wraps modulo 2^CNT_WIDTH.
- `period`  out  WIDTH  currently active period.

## Operation
- Internal: `count[WIDTH-1:0]`, period register, 2-state FSM (IDLE, RUN).
- Reset (async, any time, including mid-count) sets:
  - `count` = 0, FSM = IDLE
  - `tick` = 0, `busy` = 0, `tick_count` = 0
  - `period` = DEFAULT_PERIOD
- Periodic mode (`mode`=0):
  - IDLE→RUN when `enable`=1. RUN→IDLE when `enable`=0; `count` is held, not cleared, so resume continues mid-period.
  - In RUN, `count` increments each cycle.
  - When `count` == `period`-1: `count`←0, `tick`←1 and `tick_count`+1 on the same edge.
- One-shot mode (`mode`=1):
  - `start`=1 sets `count`←0 and FSM←RUN. This also applies in RUN (restart; no tick for the aborted period).
  - In RUN with `enable`=1, `count` increments. At `period`-1: `tick`←1, `tick_count`+1, `count`←0, FSM←IDLE.
  - `enable`=0 in RUN freezes `count`; FSM stays RUN.
- `mode` change (sampled value differs from the previous cycle's value): `count`←0, FSM←IDLE, no tick that cycle.
- `period_load`=1: period register ← max(`period_in`,1), `count`←0, and no tick that cycle even if `count` was at terminal. The FSM state is unchanged.
- Priority, highest first: `reset` > mode change > `period_load` > `start` > terminal-count/increment. `period_load` and `start` in the same cycle: both apply (new period stored, count 0, one-shot armed).
- Period 1: `tick` high every enabled RUN cycle. Periodic mode then gives a continuous high `tick`; this is the only case where `tick` exceeds one cycle.
- `tick` is 0 in any cycle not produced by a terminal count.

## Timing
- All outputs are registered; no combinational input→output paths.
- Periodic: `enable` rises before edge E0, so RUN and count=0 are reached at E0. The first `tick` is high after edge E0+P, then every P cycles.
- One-shot: `start` sampled at edge S, so count=0 at S. `tick` is high after edge S+P, and `busy` falls on that same edge.
- `busy` rises on the edge that samples `start` (one-shot) or `enable` (periodic).
- `tick_count` updates on the edge that raises `tick`.
- `period` reflects a load on the edge following the `period_load` cycle.

## Test plan
- Default period: DEFAULT_PERIOD=5, `enable`=1, mode 0 → `tick` high every 5th cycle, one cycle wide; after 10 ticks `tick_count`=10.
- One-shot: period_in=3 loaded, mode 1, `start` pulse → `tick` exactly 3 cycles later, `busy` 1→0 on that edge, no further ticks. A second `start` pulse 1 cycle before terminal → tick delayed to 3 cycles after the restart.
- Pause/load: period 8, drop `enable` at count=4 for 10 cycles → the next tick is 4 cycles after re-enable. `period_load`=2 at count=7 → no tick that cycle, then ticks every 2 cycles.
- Edge periods: period_in=0 → `period` reads 1 and `tick` is continuously high while enabled. period_in=2^WIDTH−1 is accepted unchanged.
- Wrap: CNT_WIDTH=8, 256 ticks → `tick_count` returns to 0, then 1 on the next tick.
- Async reset mid-count, asserted between clock edges → all outputs 0 and `period`=DEFAULT_PERIOD immediately. After release, first tick P cycles after enable.

Source files
------------

// File: rtl/tick_generator.sv
// Programmable tick generator: periodic or one-shot single-cycle pulses every
// `period` clocks, with a wrapping count of emitted ticks.
module tick_generator #(
  parameter int WIDTH          = 26,
  parameter int DEFAULT_PERIOD = 150000,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 period_load,
  input  logic [WIDTH-1:0]     period_in,
  output logic                 tick,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic [WIDTH-1:0]     period
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [WIDTH-1:0]     DEF_P   = WIDTH'(DEFAULT_PERIOD);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     period_q, period_d;
  logic                 tick_q, tick_d;
  logic [CNT_WIDTH-1:0] tick_count_q, tick_count_d;
  logic                 mode_q, mode_d;
  logic                 mode_seen_q, mode_seen_d;
  logic                 mode_change;
  logic                 terminal;

  // mode_seen_q masks the first post-reset cycle so the reset value of
  // mode_q never looks like a mode change.
  assign mode_change = mode_seen_q && (mode != mode_q);
  assign terminal    = (count_q == (period_q - ONE));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    period_d     = period_q;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;
    mode_d       = mode;
    mode_seen_d  = 1'b1;

    if (mode_change) begin
      count_d = '0;
      state_d = IDLE;
    end else if (period_load) begin
      period_d = (period_in == '0) ? ONE : period_in;
      count_d  = '0;
      if (mode && start) state_d = RUN;
    end else if (mode) begin
      if (start) begin
        count_d = '0;
        state_d = RUN;
      end else if ((state_q == RUN) && enable) begin
        if (terminal) begin
          tick_d       = 1'b1;
          tick_count_d = tick_count_q + CNT_ONE;
          count_d      = '0;
          state_d      = IDLE;
        end else begin
          count_d = count_q + ONE;
        end
      end
    end else begin
      // Periodic: leaving RUN keeps count so a resume continues mid-period.
      case (state_q)
        IDLE: if (enable) state_d = RUN;
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (terminal) begin
            tick_d       = 1'b1;
            tick_count_d = tick_count_q + CNT_ONE;
            count_d      = '0;
          end else begin
            count_d = count_q + ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      period_q     <= DEF_P;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      mode_q       <= 1'b0;
      mode_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      period_q     <= period_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      mode_q       <= mode_d;
      mode_seen_q  <= mode_seen_d;
    end
  end

  assign tick       = tick_q;
  assign busy       = (state_q == RUN);
  assign tick_count = tick_count_q;
  assign period     = period_q;

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with DEFAULT_PERIOD=5: periodic, one-shot,
// pause/reload, edge periods, async reset and tick_count wrap.
module tb_tick_generator;

  localparam int WIDTH = 26;
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 mode;
  logic                 start;
  logic                 period_load;
  logic [WIDTH-1:0]     period_in;
  logic                 tick;
  logic                 busy;
  logic [CNT_WIDTH-1:0] tick_count;
  logic [WIDTH-1:0]     period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_generator #(
    .WIDTH(WIDTH), .DEFAULT_PERIOD(5), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .mode(mode),
    .start(start), .period_load(period_load), .period_in(period_in),
    .tick(tick), .busy(busy), .tick_count(tick_count), .period(period)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] p);
    period_load = 1'b1;
    period_in   = p;
    step();
    period_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0;
    period_load = 1'b0; period_in = '0;
    step(); step();
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tc", tick_count, 0);
    chk("rst_period", period, 5);
    reset = 1'b0;
    step();

    // Periodic, default period 5
    enable = 1'b1;
    step();
    chk("per_busy", busy, 1);
    chk("per_e0_tick", tick, 0);
    for (int k = 1; k <= 50; k++) begin
      step();
      chk("per5_tick", tick, (k % 5 == 0) ? 1 : 0);
    end
    chk("per5_tc", tick_count, 10);

    // One-shot, period 3
    load(3);
    chk("ld3_period", period, 3);
    chk("ld3_tick", tick, 0);
    mode = 1'b1;
    step();
    chk("mchg_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("os_busy_rise", busy, 1);
    step(); chk("os_t1", tick, 0);
    step(); chk("os_t2", tick, 0);
    step();
    chk("os_tick", tick, 1);
    chk("os_busy_fall", busy, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("os_quiet", tick, 0);
    end
    chk("os_tc", tick_count, 11);

    // One-shot restart one cycle before terminal
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs_tick", tick, 0);
    chk("rs_busy", busy, 1);
    step(); chk("rs_t1", tick, 0);
    step(); chk("rs_t2", tick, 0);
    step();
    chk("rs_tick3", tick, 1);
    chk("rs_busy_fall", busy, 0);
    chk("rs_tc", tick_count, 12);

    // Pause and reload, period 8
    mode = 1'b0;
    step();
    load(8);
    chk("ld8_period", period, 8);
    step();
    chk("p8_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("p8_pre", tick, 0);
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pause_tick", tick, 0);
    end
    chk("pause_busy", busy, 0);
    enable = 1'b1;
    step();
    chk("resume_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("resume_tick", tick, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 7; k++) begin
      step();
      chk("p8_run", tick, 0);
    end
    load(2);
    chk("ld2_notick", tick, 0);
    chk("ld2_period", period, 2);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("p2_tick", tick, (k % 2 == 0) ? 1 : 0);
    end
    chk("p2_tc", tick_count, 15);

    // Edge periods
    load('0);
    chk("ld0_period", period, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("p1_tick", tick, 1);
    end
    chk("p1_tc", tick_count, 19);
    load({WIDTH{1'b1}});
    chk("ldmax_period", period, (1 << WIDTH) - 1);
    chk("ldmax_tick", tick, 0);
    step(); step();

    // Async reset between edges
    #3 reset = 1'b1;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tc", tick_count, 0);
    chk("arst_period", period, 5);
    step();
    reset = 1'b0;
    step();
    chk("post_busy", busy, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("post_tick", tick, (k == 5) ? 1 : 0);
    end
    chk("post_tc", tick_count, 1);

    // tick_count wrap with period 1
    load(1);
    chk("wr_ld_tick", tick, 0);
    for (int k = 0; k < 255; k++) step();
    chk("wr_tick", tick, 1);
    chk("wr_tc0", tick_count, 0);
    step();
    chk("wr_tc1", tick_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
